// File: rtl/memwb_skid_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer (OUT + SKD), flush,
// x0 write masking and a retire counter. Strict FIFO order, no drops under back-pressure.
module memwb_skid_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pcn_i,
  input  logic                  erd_i,
  input  logic [DATA_WIDTH-1:0] wbrd_i,
  input  logic [RF_SIZE-1:0]    rd_i,
  input  logic                  ememw_i,
  input  logic [DATA_WIDTH-1:0] wbmem_i,
  input  logic [DATA_WIDTH-1:0] memaddr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pcn_o,
  output logic                  erd_o,
  output logic [DATA_WIDTH-1:0] wbrd_o,
  output logic [RF_SIZE-1:0]    rd_o,
  output logic                  ememw_o,
  output logic [DATA_WIDTH-1:0] wbmem_o,
  output logic [DATA_WIDTH-1:0] memaddr_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcn;
    logic                  erd;
    logic [DATA_WIDTH-1:0] wbrd;
    logic [RF_SIZE-1:0]    rd;
    logic                  ememw;
    logic [DATA_WIDTH-1:0] wbmem;
    logic [DATA_WIDTH-1:0] memaddr;
  } ent_t;

  ent_t                 in_ent, out_q, out_d, skd_q, skd_d;
  logic                 vo_q, vo_d, skv_q, skv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 acc, drn;

  always_comb begin
    in_ent.pc      = pc_i;
    in_ent.pcn     = pcn_i;
    in_ent.erd     = erd_i & (rd_i != '0);  // writes to x0 are never architecturally visible
    in_ent.wbrd    = wbrd_i;
    in_ent.rd      = rd_i;
    in_ent.ememw   = ememw_i;
    in_ent.wbmem   = wbmem_i;
    in_ent.memaddr = memaddr_i;
  end

  assign acc = valid_i & ~skv_q & ~flush_i;
  assign drn = vo_q & ready_i;

  always_comb begin
    out_d = out_q;
    skd_d = skd_q;
    vo_d  = vo_q;
    skv_d = skv_q;
    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, drn};
    if (flush_i) begin
      vo_d  = 1'b0;
      skv_d = 1'b0;
    end else if (skv_q) begin
      if (drn) begin
        out_d = skd_q;
        skv_d = 1'b0;
      end
    end else if (vo_q) begin
      if (drn && acc)  out_d = in_ent;
      else if (drn)    vo_d  = 1'b0;
      else if (acc) begin
        skd_d = in_ent;
        skv_d = 1'b1;
      end
    end else if (acc) begin
      out_d = in_ent;
      vo_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      skd_q <= '0;
      vo_q  <= 1'b0;
      skv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skd_q <= skd_d;
      vo_q  <= vo_d;
      skv_q <= skv_d;
      cnt_q <= cnt_d;
    end
  end

  assign ready_o   = ~skv_q;
  assign valid_o   = vo_q;
  assign pc_o      = out_q.pc;
  assign pcn_o     = out_q.pcn;
  assign erd_o     = out_q.erd & vo_q;  // side effects gated off on bubbles
  assign wbrd_o    = out_q.wbrd;
  assign rd_o      = out_q.rd;
  assign ememw_o   = out_q.ememw & vo_q;
  assign wbmem_o   = out_q.wbmem;
  assign memaddr_o = out_q.memaddr;
  assign instret_o = cnt_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: directed scenarios plus random traffic checked
// against a depth-2 FIFO reference model; a 4-bit-counter instance checks wrap.
module tb_memwb_skid_stage;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, vin = 1'b0, rdy = 1'b0;
  logic [63:0] pc = '0, pcn = '0, wbrd = '0, wbmem = '0, maddr = '0;
  logic        erd = 1'b0, ememw = 1'b0;
  logic [4:0]  rd = '0;

  logic        ready_o, valid_o, erd_o, ememw_o;
  logic [63:0] pc_o, pcn_o, wbrd_o, wbmem_o, maddr_o, instret_o;
  logic [4:0]  rd_o;
  logic        b_ready, b_valid, b_erd, b_ememw;
  logic [63:0] b_pc, b_pcn, b_wbrd, b_wbmem, b_maddr;
  logic [4:0]  b_rd;
  logic [3:0]  b_instret;

  int total = 0, bad = 0;

  typedef struct {
    logic [63:0] pc, pcn, wbrd, wbmem, maddr;
    logic        erd, ememw;
    logic [4:0]  rd;
  } ent_t;
  ent_t        q[$];
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  memwb_skid_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(ready_o),
    .pc_i(pc), .pcn_i(pcn), .erd_i(erd), .wbrd_i(wbrd), .rd_i(rd), .ememw_i(ememw),
    .wbmem_i(wbmem), .memaddr_i(maddr), .valid_o(valid_o), .ready_i(rdy),
    .pc_o(pc_o), .pcn_o(pcn_o), .erd_o(erd_o), .wbrd_o(wbrd_o), .rd_o(rd_o),
    .ememw_o(ememw_o), .wbmem_o(wbmem_o), .memaddr_o(maddr_o), .instret_o(instret_o)
  );

  memwb_skid_stage #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(b_ready),
    .pc_i(pc), .pcn_i(pcn), .erd_i(erd), .wbrd_i(wbrd), .rd_i(rd), .ememw_i(ememw),
    .wbmem_i(wbmem), .memaddr_i(maddr), .valid_o(b_valid), .ready_i(rdy),
    .pc_o(b_pc), .pcn_o(b_pcn), .erd_o(b_erd), .wbrd_o(b_wbrd), .rd_o(b_rd),
    .ememw_o(b_ememw), .wbmem_o(b_wbmem), .memaddr_o(b_maddr), .instret_o(b_instret)
  );

  // Reference: the stage is a 2-deep FIFO; ready while fewer than 2 are held.
  task automatic model_edge();
    int   sz;
    bit   dr;
    ent_t e;
    sz = q.size();
    dr = (sz > 0) && rdy;
    if (dr) m_cnt++;
    if (flush) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (vin && sz < 2) begin
        e.pc = pc; e.pcn = pcn; e.wbrd = wbrd; e.wbmem = wbmem; e.maddr = maddr;
        e.erd = erd && (rd != 0); e.ememw = ememw; e.rd = rd;
        q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic e, input logic [4:0] r,
                       input logic m);
    vin = v; pc = p; pcn = p + 64'd4; erd = e; rd = r; ememw = m;
    wbrd = p ^ 64'h5555; wbmem = ~p; maddr = p + 64'h1000;
  endtask

  task automatic do_reset();
    vin = 0; flush = 0; rdy = 0;
    #2 rst = 1;
    #3 rst = 0;
    q.delete(); m_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({valid_o, ready_o, erd_o, ememw_o, instret_o, pc_o, rd_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0}) begin
      bad++; $display("FAIL reset: got v=%b r=%b erd=%b mw=%b cnt=%0d pc=%h rd=%0d need v=0 r=1 erd=0 mw=0 cnt=0 pc=0 rd=0",
                      valid_o, ready_o, erd_o, ememw_o, instret_o, pc_o, rd_o);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] exp_pc;
    do_reset();
    rdy = 1;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 64'h8000_0000 + 64'(4 * k);
      drive(1, exp_pc, 1, 5'd1, 0);
      step();
      total++;
      if ({valid_o, ready_o, pc_o} !== {1'b1, 1'b1, exp_pc}) begin
        bad++; $display("FAIL stream%0d: got v=%b r=%b pc=%h need v=1 r=1 pc=%h", k, valid_o, ready_o, pc_o, exp_pc);
      end
    end
    vin = 0;
    step();
    total++;
    if (instret_o !== 64'd4 || valid_o !== 1'b0) begin
      bad++; $display("FAIL stream_cnt: got cnt=%0d v=%b need cnt=4 v=0", instret_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 0;
    drive(1, 64'h100, 0, 5'd2, 0); step();
    drive(1, 64'h104, 0, 5'd2, 0); step();
    vin = 0;
    total++;
    if ({valid_o, ready_o, pc_o} !== {1'b1, 1'b0, 64'h100}) begin
      bad++; $display("FAIL bp_hold: got v=%b r=%b pc=%h need v=1 r=0 pc=100", valid_o, ready_o, pc_o);
    end
    step();
    total++;
    if ({valid_o, ready_o, pc_o} !== {1'b1, 1'b0, 64'h100}) begin
      bad++; $display("FAIL bp_stable: got v=%b r=%b pc=%h need v=1 r=0 pc=100", valid_o, ready_o, pc_o);
    end
    rdy = 1; step();
    total++;
    if ({valid_o, ready_o, pc_o} !== {1'b1, 1'b1, 64'h104}) begin
      bad++; $display("FAIL bp_second: got v=%b r=%b pc=%h need v=1 r=1 pc=104", valid_o, ready_o, pc_o);
    end
    step();
    total++;
    if (valid_o !== 1'b0 || instret_o !== 64'd2) begin
      bad++; $display("FAIL bp_empty: got v=%b cnt=%0d need v=0 cnt=2", valid_o, instret_o);
    end
  endtask

  task automatic test_x0_mask();
    do_reset();
    rdy = 1;
    drive(1, 64'h300, 1, 5'd0, 0); wbrd = 64'hDEAD; step();
    total++;
    if ({valid_o, erd_o, wbrd_o} !== {1'b1, 1'b0, 64'hDEAD}) begin
      bad++; $display("FAIL x0_mask: got v=%b erd=%b wbrd=%h need v=1 erd=0 wbrd=dead", valid_o, erd_o, wbrd_o);
    end
    drive(1, 64'h304, 1, 5'd5, 0); step();
    total++;
    if ({valid_o, erd_o, rd_o} !== {1'b1, 1'b1, 5'd5}) begin
      bad++; $display("FAIL x0_rd5: got v=%b erd=%b rd=%0d need v=1 erd=1 rd=5", valid_o, erd_o, rd_o);
    end
    vin = 0;
  endtask

  task automatic test_flush();
    do_reset();
    rdy = 0;
    drive(1, 64'h180, 1, 5'd3, 1); step();
    drive(1, 64'h184, 1, 5'd3, 1); step();
    drive(1, 64'h200, 1, 5'd3, 1); flush = 1; step();
    flush = 0; vin = 0;
    total++;
    if ({valid_o, erd_o, ememw_o, ready_o} !== 4'b0001) begin
      bad++; $display("FAIL flush: got v=%b erd=%b mw=%b r=%b need v=0 erd=0 mw=0 r=1", valid_o, erd_o, ememw_o, ready_o);
    end
    rdy = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (valid_o !== 1'b0 || instret_o !== 64'd0) begin
        bad++; $display("FAIL flush_gone%0d: got v=%b pc=%h cnt=%0d need v=0 cnt=0", k, valid_o, pc_o, instret_o);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rdy = 1;
    drive(1, 64'h40, 1, 5'd7, 1); step();
    rdy = 0;
    drive(1, 64'h44, 1, 5'd7, 1); step();
    drive(1, 64'h48, 1, 5'd7, 1); step();
    vin = 0;
    #2 rst = 1;
    #1;
    total++;
    if ({valid_o, ready_o, erd_o, ememw_o, instret_o, pc_o, wbrd_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0}) begin
      bad++; $display("FAIL async_rst: got v=%b r=%b erd=%b mw=%b cnt=%0d pc=%h need all 0, r=1",
                      valid_o, ready_o, erd_o, ememw_o, instret_o, pc_o);
    end
    #1 rst = 0;
    q.delete(); m_cnt = 0;
    rdy = 1; step(); step();
    total++;
    if (valid_o !== 1'b0 || instret_o !== 64'd0) begin
      bad++; $display("FAIL async_skid_gone: got v=%b cnt=%0d need v=0 cnt=0", valid_o, instret_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rdy = 1;
    for (int k = 0; k < 17; k++) begin
      drive(1, 64'(k * 4), 0, 5'd1, 0); step();
    end
    vin = 0; step();
    total++;
    if (b_instret !== 4'd1 || instret_o !== 64'd17) begin
      bad++; $display("FAIL wrap: got cnt4=%0d cnt=%0d need cnt4=1 cnt=17", b_instret, instret_o);
    end
  endtask

  task automatic test_random();
    ent_t e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      vin   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      pc = {$urandom, $urandom}; pcn = {$urandom, $urandom};
      wbrd = {$urandom, $urandom}; wbmem = {$urandom, $urandom}; maddr = {$urandom, $urandom};
      erd = 1'($urandom); ememw = 1'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step();
      total++;
      if (q.size() > 0) begin
        e = q[0];
        if ({valid_o, ready_o, pc_o, pcn_o, erd_o, wbrd_o, rd_o, ememw_o, wbmem_o, maddr_o, instret_o} !==
            {1'b1, q.size() < 2, e.pc, e.pcn, e.erd, e.wbrd, e.rd, e.ememw, e.wbmem, e.maddr, m_cnt}) begin
          bad++; $display("FAIL rand%0d: got v=%b r=%b pc=%h erd=%b rd=%0d mw=%b cnt=%0d need v=1 r=%b pc=%h erd=%b rd=%0d mw=%b cnt=%0d",
                          c, valid_o, ready_o, pc_o, erd_o, rd_o, ememw_o, instret_o,
                          q.size() < 2, e.pc, e.erd, e.rd, e.ememw, m_cnt);
        end
      end else if ({valid_o, ready_o, erd_o, ememw_o, instret_o} !== {1'b0, 1'b1, 1'b0, 1'b0, m_cnt}) begin
        bad++; $display("FAIL rand%0d_empty: got v=%b r=%b erd=%b mw=%b cnt=%0d need v=0 r=1 erd=0 mw=0 cnt=%0d",
                        c, valid_o, ready_o, erd_o, ememw_o, instret_o, m_cnt);
      end
      total++;
      if (b_instret !== m_cnt[3:0]) begin
        bad++; $display("FAIL rand%0d_cnt4: got %0d need %0d", c, b_instret, m_cnt[3:0]);
      end
    end
    flush = 0; vin = 0;
  endtask

  initial begin
    m_cnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_x0_mask();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
